// File: rtl/bus_extender_nport_pkg.sv
// Shared definitions for the N-port bus extender: arbitration modes and the
// port-index width helper.
package bus_extender_nport_pkg;

  localparam int FIXED = 0;
  localparam int RR    = 1;

  // Width of a port index; a single port still gets one (always-zero) bit.
  function automatic int port_width(input int num_ports);
    return (num_ports <= 1) ? 1 : $clog2(num_ports);
  endfunction

endpackage

// File: rtl/bus_extender_nport_arbiter.sv
// Combinational arbiter: fixed priority (lowest index wins) or round-robin
// search starting at pointer and wrapping past the top port.
module bus_arbiter_rr
  import bus_extender_nport_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MODE      = FIXED,
  localparam int PW       = port_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [PW-1:0]        pointer,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        index
);

  logic [PW-1:0] base;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;
  logic          found;

  assign base = (MODE == RR) ? pointer : '0;

  // Candidates are visited in order base, base+1, ... modulo NUM_PORTS; the
  // first valid one wins, so fixed mode is simply a search from base 0.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, base} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_PORTS)) begin
        sum = sum - (PW+1)'(NUM_PORTS);
      end
      cand = sum[PW-1:0];
      if (!found && |(valid & (NUM_PORTS'(1) << cand))) begin
        found = 1'b1;
        grant = NUM_PORTS'(1) << cand;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/bus_extender_nport.sv
// N-port bus extender: arbitrates among per-port valid/data inputs and
// registers the winner with one cycle of latency, tracking collisions.
module bus_extender_nport
  import bus_extender_nport_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PORTS   = 4,
  parameter int ROUND_ROBIN = 0,
  parameter int CNT_WIDTH   = 16,
  localparam int PW         = port_width(NUM_PORTS)
) (
  input  logic                            bus_clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            bus_valid_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] bus_data_i,
  input  logic                            collision_clear_i,
  output logic                            bus_valid_o,
  output logic [DATA_WIDTH-1:0]           bus_data_o,
  output logic [NUM_PORTS-1:0]            bus_grant_o,
  output logic [PW-1:0]                   bus_port_o,
  output logic                            collision_o,
  output logic [CNT_WIDTH-1:0]            collision_count_o
);

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         ptr_next;
  logic [NUM_PORTS-1:0]  arb_grant;
  logic [PW-1:0]         arb_index;
  logic [DATA_WIDTH-1:0] data_sel;
  logic                  any_valid;
  logic                  collision;

  bus_arbiter_rr #(
    .NUM_PORTS (NUM_PORTS),
    .MODE      ((ROUND_ROBIN != 0) ? RR : FIXED)
  ) u_arbiter (
    .valid   (bus_valid_i),
    .pointer (rr_ptr),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  assign any_valid = |bus_valid_i;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign collision = |(bus_valid_i & (bus_valid_i - NUM_PORTS'(1)));
  assign ptr_next  = (arb_index == PW'(NUM_PORTS - 1)) ? '0 : arb_index + PW'(1);

  // The grant is one-hot (or zero when idle), so an AND-OR mux suffices and
  // naturally yields zero data when no port is valid.
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      data_sel = data_sel | ({DATA_WIDTH{arb_grant[k]}} & bus_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge bus_clock or posedge reset) begin
    if (reset) begin
      bus_valid_o       <= 1'b0;
      bus_data_o        <= '0;
      bus_grant_o       <= '0;
      bus_port_o        <= '0;
      rr_ptr            <= '0;
      collision_o       <= 1'b0;
      collision_count_o <= '0;
    end else begin
      bus_valid_o <= any_valid;
      bus_data_o  <= data_sel;
      bus_grant_o <= arb_grant;
      bus_port_o  <= arb_index;
      if (any_valid) begin
        rr_ptr <= ptr_next;
      end
      // A collision in the same cycle as a clear restarts the count at one.
      if (collision) begin
        collision_o <= 1'b1;
        if (collision_clear_i) begin
          collision_count_o <= CNT_WIDTH'(1);
        end else if (collision_count_o != '1) begin
          collision_count_o <= collision_count_o + CNT_WIDTH'(1);
        end
      end else if (collision_clear_i) begin
        collision_o       <= 1'b0;
        collision_count_o <= '0;
      end
    end
  end

endmodule

// File: doc/bus_extender_nport.md
BUS_EXTENDER_NPORT -- requirements
Module: bus_extender_nport

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width of every port.
REQ-002 The block SHALL have parameter NUM_PORTS, default 4, giving the number of input ports; legal range 1..16.
REQ-003 The block SHALL have parameter ROUND_ROBIN, default 0, where 0 selects fixed priority and 1 selects round-robin arbitration.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 16, giving the collision counter width.
REQ-005 The block SHALL have bus_clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 The block SHALL have reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have bus_valid_i  input  NUM_PORTS  per-port valid; bit k belongs to port k.
REQ-008 The block SHALL have bus_data_i  input  NUM_PORTS*DATA_WIDTH  per-port data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have collision_clear_i  input  1  clears the collision flag and counter.
REQ-010 The block SHALL have bus_valid_o  output  1  registered merged valid.
REQ-011 The block SHALL have bus_data_o  output  DATA_WIDTH  registered data of the granted port.
REQ-012 The block SHALL have bus_grant_o  output  NUM_PORTS  registered one-hot grant.
REQ-013 The block SHALL have bus_port_o  output  PW  registered index of the granted port, where PW = max(1, clog2(NUM_PORTS)).
REQ-014 The block SHALL have collision_o  output  1  sticky collision flag.
REQ-015 The block SHALL have collision_count_o  output  CNT_WIDTH  saturating collision count.

Function
REQ-016 Latency SHALL be exactly one cycle: inputs sampled at edge t appear on bus_valid_o/bus_data_o/bus_grant_o/bus_port_o after edge t.
REQ-017 bus_valid_o SHALL be the registered OR of all bus_valid_i bits.
REQ-018 When no port is valid, bus_data_o, bus_grant_o and bus_port_o SHALL all register zero.
REQ-019 In fixed-priority mode, the valid port with the lowest index SHALL win.
REQ-020 In round-robin mode, a pointer rr_ptr (range 0..NUM_PORTS-1) SHALL select the first valid port at or above rr_ptr, wrapping from NUM_PORTS-1 to 0.
REQ-021 After a grant to port k, rr_ptr SHALL become k+1, wrapping to 0 when k = NUM_PORTS-1.
REQ-022 When no port is valid, rr_ptr SHALL hold its value.
REQ-023 A collision is a cycle in which two or more bus_valid_i bits are set; it SHALL set collision_o and increment collision_count_o by 1.
REQ-024 collision_count_o SHALL saturate at all-ones and SHALL NOT wrap.
REQ-025 collision_clear_i alone SHALL zero collision_o and collision_count_o at the next edge.
REQ-026 When collision_clear_i coincides with a collision, the collision SHALL win: collision_o = 1 and collision_count_o = 1.
REQ-027 Arbitration SHALL still grant exactly one port during a collision; the data of losing ports SHALL be dropped, with no buffering.
REQ-028 For NUM_PORTS = 1, the block SHALL act as a one-stage register, never collide, and tie bus_port_o to 0.

Reset
REQ-029 On assertion of reset, all outputs, rr_ptr and the counter SHALL go to zero immediately, without waiting for a clock edge.
REQ-030 Reset SHALL take priority over every input, and the first grant after release SHALL be evaluated from rr_ptr = 0.
REQ-031 If reset is asserted during a collision or mid-transfer, the in-flight sample SHALL be discarded and SHALL NOT be counted.

Structure
REQ-032 The function for the port-index width PW and the arbitration mode constants (FIXED = 0, RR = 1) SHALL reside in the shared peripheral package.
REQ-033 Arbitration SHALL be one combinational sub-module, bus_arbiter_rr, with inputs valid and pointer, a mode parameter, and outputs one-hot grant and index; the top-level block SHALL hold all registers.

Verification
REQ-034 Fixed mode, NUM_PORTS = 4: drive valid = 4'b0110 with port1 = 0x11111111 and port2 = 0x22222222; next cycle SHALL show bus_data_o = 0x11111111, bus_grant_o = 4'b0010, bus_port_o = 1, collision_count_o = 1.
REQ-035 Round-robin mode: hold valid = 4'b1111 for 5 cycles; grants SHALL be ports 0, 1, 2, 3, 0 and collision_count_o SHALL reach 5.
REQ-036 Round-robin wrap: with rr_ptr = 3 and valid = 4'b0001, port 0 SHALL be granted and rr_ptr SHALL become 1.
REQ-037 Saturation: with CNT_WIDTH = 2, apply 5 collision cycles; collision_count_o SHALL equal 3; asserting collision_clear_i with valid = 0 SHALL give 0 and collision_o = 0 next cycle.
REQ-038 Assert collision_clear_i together with valid = 4'b0011; next cycle SHALL show collision_count_o = 1 and collision_o = 1.
REQ-039 Assert reset asynchronously mid-cycle while bus_valid_o = 1; all outputs SHALL read 0 before the next edge.
